// File: rtl/battle_pkg.sv
// Shared constants for the PS/2 keyboard front end: HID usages, set-2 scancodes,
// PS/2 prefix bytes and the receiver frame state type.
package battle_pkg;

  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_W    = 8'h1A;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_D    = 8'h07;
  localparam logic [7:0] KEY_J    = 8'h0D;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_J     = 8'h3B;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Unmapped scancodes translate to KEY_NONE so the key table ignores them.
  function automatic logic [7:0] sc_to_usage(input logic [7:0] sc);
    logic [7:0] usage;
    case (sc)
      SC_W:    usage = KEY_W;
      SC_A:    usage = KEY_A;
      SC_S:    usage = KEY_S;
      SC_D:    usage = KEY_D;
      SC_J:    usage = KEY_J;
      default: usage = KEY_NONE;
    endcase
    return usage;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, start/data/parity/stop
// FSM and an inactivity watchdog that abandons partial frames.
module ps2_rx
  import battle_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       err
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   data_bit;

  ps2_state_t             state, state_nxt;
  logic [2:0]             cnt, cnt_nxt;
  logic [WD_W-1:0]        wdog, wdog_nxt;
  logic                   valid_nxt;
  logic                   err_nxt;
  logic                   shift_en;
  logic                   par_en;
  logic [7:0]             shreg;
  logic                   par;

  // Synchronizers idle high so a reset never looks like a falling edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall     = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign data_bit = data_sync[SYNC_STAGES-1];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      wdog       <= '0;
      byte_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      wdog       <= wdog_nxt;
      byte_valid <= valid_nxt;
      err        <= err_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (shift_en) shreg <= {data_bit, shreg[7:1]};
    if (par_en)   par   <= data_bit;
  end

  // An edge arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wdog_nxt  = wdog;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    if (fall) begin
      wdog_nxt = '0;
      case (state)
        IDLE: begin
          if (!data_bit) begin
            state_nxt = DATA;
            cnt_nxt   = 3'd0;
          end else begin
            err_nxt = 1'b1;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          cnt_nxt  = cnt + 3'd1;
          if (cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_en    = 1'b1;
          state_nxt = STOP;
        end
        STOP: begin
          if (data_bit && (^{shreg, par})) valid_nxt = 1'b1;
          else                             err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state == IDLE) begin
      wdog_nxt = '0;
    end else if (wdog == WD_LAST) begin
      state_nxt = IDLE;
      err_nxt   = 1'b1;
      wdog_nxt  = '0;
    end else begin
      wdog_nxt = wdog + WD_W'(1);
    end
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/keycode_decoder.sv
// PS/2 set-2 keyboard front end producing the two-slot HID keycode word
// consumed by the tank and bullet movement logic.
module keycode_decoder
  import battle_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        key_valid,
  output logic        frame_err
);

  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic        rx_err;

  logic        ext;
  logic        brk;
  logic [7:0]  slot0, slot0_nxt;
  logic [7:0]  slot1, slot1_nxt;
  logic [7:0]  usage;
  logic        is_prefix;
  logic [15:0] keycode_p1;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .err       (rx_err)
  );

  assign is_prefix = (rx_byte == PS2_EXT) || (rx_byte == PS2_BRK);
  assign usage     = ext ? KEY_NONE : sc_to_usage(rx_byte);

  // Break of slot0 shifts slot1 down so a lone held key is always in the low byte.
  always_comb begin
    slot0_nxt = slot0;
    slot1_nxt = slot1;
    if (byte_valid && !is_prefix && (usage != KEY_NONE)) begin
      if (!brk) begin
        if ((usage != slot0) && (usage != slot1)) begin
          if (slot0 == KEY_NONE)      slot0_nxt = usage;
          else if (slot1 == KEY_NONE) slot1_nxt = usage;
        end
      end else if (slot1 == usage) begin
        slot1_nxt = KEY_NONE;
      end else if (slot0 == usage) begin
        slot0_nxt = slot1;
        slot1_nxt = KEY_NONE;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      slot0      <= KEY_NONE;
      slot1      <= KEY_NONE;
      keycode_p1 <= 16'h0000;
      key_valid  <= 1'b0;
    end else begin
      if (rx_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (rx_byte == PS2_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == PS2_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
      slot0      <= slot0_nxt;
      slot1      <= slot1_nxt;
      // key_valid lands one cycle after the new keycode becomes visible.
      keycode_p1 <= keycode;
      key_valid  <= (keycode != keycode_p1);
    end
  end

  assign keycode   = {slot1, slot0};
  assign frame_err = rx_err;

endmodule

// File: tb/tb_keycode_decoder.sv
// Directed bench for keycode_decoder: bit-banged PS/2 frames with hand-computed keycodes.
module tb_keycode_decoder;
  import battle_pkg::*;

  localparam int TO = 200;
  localparam int H  = 8;

  logic        Clk      = 1'b0;
  logic        Reset_n  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] keycode;
  logic        key_valid;
  logic        frame_err;

  int total  = 0;
  int bad    = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;

  always #5 Clk = ~Clk;

  keycode_decoder #(
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES   (2)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .keycode  (keycode),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  // Pulse counters plus a running check that key_valid follows every keycode change by one cycle.
  logic [15:0] kc_h1 = 16'h0;
  logic [15:0] kc_h0 = 16'h0;
  logic [2:0]  rst_h = 3'b000;
  always @(negedge Clk) begin
    if (key_valid === 1'b1) kv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
    rst_h = {rst_h[1:0], Reset_n};
    if (rst_h == 3'b111) begin
      total++;
      assert (key_valid === (kc_h1 != kc_h0)) else begin
        bad++;
        $error("FAIL kv_timing: observed=%b expected=%b", key_valid, (kc_h1 != kc_h0));
      end
    end
    kc_h0 = kc_h1;
    kc_h1 = keycode;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      tick(H);
      ps2_clk = 1'b0;
      tick(H);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = (~^b) ^ bad_par;
    send_bits({~bad_stop, p, b, 1'b0}, 11);
    ps2_data = 1'b1;
    tick(24);
  endtask

  task automatic key_step(input string tag, input logic [7:0] b,
                          input logic [15:0] exp_kc, input int exp_kv);
    int kv0;
    int fe0;
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_frame(b, 1'b0, 1'b0);
    check({tag, "_kc"}, keycode, exp_kc);
    check({tag, "_kv"}, 16'(kv_cnt - kv0), 16'(exp_kv));
    check({tag, "_fe"}, 16'(fe_cnt - fe0), 16'd0);
  endtask

  initial begin
    int fe0;
    int kv0;
    int waited;

    // Reset state
    tick(4);
    check("rst_kc", keycode, 16'h0000);
    check("rst_kv", {15'd0, key_valid}, 16'd0);
    check("rst_fe", {15'd0, frame_err}, 16'd0);
    check("rst_state", {14'd0, dut.u_rx.state}, 16'(IDLE));
    Reset_n = 1'b1;
    tick(10);

    // Two makes fill both slots
    key_step("mk_j", SC_J, 16'h000D, 1);
    key_step("mk_w", SC_W, 16'h1A0D, 1);

    // Break slot0 shifts slot1 down, then release the last key
    key_step("brk1_f0", PS2_BRK, 16'h1A0D, 0);
    key_step("brk_j", SC_J, 16'h001A, 1);
    key_step("brk2_f0", PS2_BRK, 16'h001A, 0);
    key_step("brk_w", SC_W, 16'h0000, 1);

    // Rollover: third make and repeated make ignored
    key_step("mk_a", SC_A, 16'h0004, 1);
    key_step("mk_s", SC_S, 16'h1604, 1);
    key_step("mk_d3", SC_D, 16'h1604, 0);
    key_step("mk_a_rep", SC_A, 16'h1604, 0);
    key_step("brk3_f0", PS2_BRK, 16'h1604, 0);
    key_step("brk_s1", SC_S, 16'h0004, 1);
    key_step("brk4_f0", PS2_BRK, 16'h0004, 0);
    key_step("brk_d_nh", SC_D, 16'h0004, 0);
    key_step("brk5_f0", PS2_BRK, 16'h0004, 0);
    key_step("brk_a", SC_A, 16'h0000, 1);

    // Bad parity, bad stop and bad start each raise frame_err
    fe0 = fe_cnt;
    kv0 = kv_cnt;
    send_frame(SC_W, 1'b1, 1'b0);
    check("par_fe", 16'(fe_cnt - fe0), 16'd1);
    check("par_kc", keycode, 16'h0000);
    check("par_kv", 16'(kv_cnt - kv0), 16'd0);
    key_step("par_good", SC_W, 16'h001A, 1);
    fe0 = fe_cnt;
    send_frame(PS2_BRK, 1'b0, 1'b1);
    check("stop_fe", 16'(fe_cnt - fe0), 16'd1);
    check("stop_brk", {15'd0, dut.brk}, 16'd0);
    key_step("stop_mk_w", SC_W, 16'h001A, 0);
    fe0 = fe_cnt;
    ps2_data = 1'b1;
    tick(H);
    ps2_clk = 1'b0;
    tick(H);
    ps2_clk = 1'b1;
    tick(24);
    check("start_fe", 16'(fe_cnt - fe0), 16'd1);
    check("start_state", {14'd0, dut.u_rx.state}, 16'(IDLE));
    key_step("brk6_f0", PS2_BRK, 16'h001A, 0);
    key_step("brk_w2", SC_W, 16'h0000, 1);

    // Extended prefix suppresses the lookup and then clears
    key_step("ext_e0", PS2_EXT, 16'h0000, 0);
    check("ext_set", {15'd0, dut.ext}, 16'd1);
    key_step("ext_w", SC_W, 16'h0000, 0);
    key_step("ext_a", SC_A, 16'h0004, 1);
    check("ext_clr", {15'd0, dut.ext}, 16'd0);
    key_step("ext2_e0", PS2_EXT, 16'h0004, 0);
    key_step("ext2_f0", PS2_BRK, 16'h0004, 0);
    key_step("ext2_a", SC_A, 16'h0004, 0);
    key_step("brk7_f0", PS2_BRK, 16'h0004, 0);
    key_step("brk_a2", SC_A, 16'h0000, 1);

    // Watchdog: abandon after 4 data bits
    fe0 = fe_cnt;
    send_bits({2'b11, SC_J, 1'b0}, 5);
    ps2_data = 1'b1;
    waited = 0;
    while ((fe_cnt == fe0) && (waited < TO + 100)) begin
      tick(1);
      waited++;
    end
    tick(2);
    check("to_fe", 16'(fe_cnt - fe0), 16'd1);
    check("to_state", {14'd0, dut.u_rx.state}, 16'(IDLE));
    check("to_delay", {15'd0, (waited >= TO - H - 10) && (waited <= TO - H + 10)}, 16'd1);
    check("to_kc", keycode, 16'h0000);
    key_step("to_mk_j", SC_J, 16'h000D, 1);

    // Reset mid-frame clears keys immediately
    send_bits({2'b11, SC_A, 1'b0}, 4);
    Reset_n = 1'b0;
    #1;
    check("mrst_kc", keycode, 16'h0000);
    tick(3);
    ps2_data = 1'b1;
    ps2_clk  = 1'b1;
    check("mrst_state", {14'd0, dut.u_rx.state}, 16'(IDLE));
    Reset_n = 1'b1;
    tick(10);
    key_step("mrst_mk_w", SC_W, 16'h001A, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
